// File: rtl/mac_dot_seq.sv
// mac_dot_seq: streams operand pairs through an external combinational multiplier
// and accumulates the products of each vector. Define SAT_EN to saturate the sum on overflow.
module mac_dot_seq #(
   parameter int IN_W  = 4,
   parameter int P_W   = 8,
   parameter int ACC_W = 12,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_x,
   input  logic [IN_W-1:0]  in_y,
   input  logic             in_last,
   output logic [IN_W-1:0]  mult_x,
   output logic [IN_W-1:0]  mult_y,
   input  logic [P_W-1:0]   mult_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             dbg_state
);

   // Both ports use valid/ready: a beat moves only on a rising edge where valid && ready;
   // the producer keeps its payload stable while valid is high and ready is low.
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t             r_state;
   logic [IN_W-1:0]    r_mult_x;
   logic [IN_W-1:0]    r_mult_y;
   logic               r_s1_v;
   logic               r_s1_last;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic               r_out_valid;
   logic [ACC_W-1:0]   r_out_sum;
   logic [CNT_W-1:0]   r_out_count;
   logic               r_out_ovf;

   logic               w_in_xfer;
   logic               w_s1_closing;
   logic [ACC_W:0]     w_nxt;
   logic [ACC_W-1:0]   w_sum;
   logic [CNT_W-1:0]   w_cnt;
   logic               w_ovf;

   // A closing pair sitting in S1 blocks new input so the next vector starts clean.
   assign w_s1_closing = r_s1_v && r_s1_last;
   assign in_ready     = (r_state == ACCUM) && !w_s1_closing;
   assign w_in_xfer    = in_valid && in_ready;

   assign w_nxt = {1'b0, r_acc} + (ACC_W+1)'(mult_p);
   assign w_cnt = r_cnt + CNT_W'(1);
   assign w_ovf = r_ovf | w_nxt[ACC_W];

`ifdef SAT_EN
   // Once the vector has overflowed the sum pins at full scale until the vector closes.
   always_comb begin
      w_sum = w_nxt[ACC_W-1:0];
      if (w_nxt[ACC_W] || r_ovf) begin
         w_sum = '1;
      end
   end
`else
   always_comb begin
      w_sum = w_nxt[ACC_W-1:0];
   end
`endif

   // Operand stage and accumulate stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mult_x    <= '0;
         r_mult_y    <= '0;
         r_s1_v      <= 1'b0;
         r_s1_last   <= 1'b0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_sum   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         r_s1_v <= w_in_xfer;
         if (w_in_xfer) begin
            r_mult_x  <= in_x;
            r_mult_y  <= in_y;
            r_s1_last <= in_last;
         end
         if (r_s1_v) begin
            if (!r_s1_last) begin
               r_acc <= w_sum;
               r_cnt <= w_cnt;
               r_ovf <= w_ovf;
            end else begin
               r_out_sum   <= w_sum;
               r_out_count <= w_cnt;
               r_out_ovf   <= w_ovf;
               r_acc       <= '0;
               r_cnt       <= '0;
               r_ovf       <= 1'b0;
            end
         end
      end
   end

   // Result handshake control.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ACCUM;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_s1_closing) begin
                  r_out_valid <= 1'b1;
                  r_state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ACCUM;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= ACCUM;
            end
         endcase
      end
   end

   assign mult_x    = r_mult_x;
   assign mult_y    = r_mult_y;
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_count = r_out_count;
   assign out_ovf   = r_out_ovf;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq: directed and randomized checks of mac_dot_seq against a per-vector
// arithmetic model (sum of products, pair count, overflow). Honours SAT_EN.
module tb_mac_dot_seq;

  localparam int IN_W  = 4;
  localparam int P_W   = 8;
  localparam int ACC_W = 12;
  localparam int CNT_W = 5;
  localparam int EW    = 1 + CNT_W + ACC_W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_x;
  logic [IN_W-1:0]  in_y;
  logic             in_last;
  logic [IN_W-1:0]  mult_x;
  logic [IN_W-1:0]  mult_y;
  logic [P_W-1:0]   mult_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  int            m_total;
  int            m_n;

  mac_dot_seq #(.IN_W(IN_W), .P_W(P_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .mult_x(mult_x), .mult_y(mult_y), .mult_p(mult_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf),
    .dbg_state(dbg_state)
  );

  // external 4x4 multiplier
  assign mult_p = mult_x * mult_y;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_pair(input logic [IN_W-1:0] x, input logic [IN_W-1:0] y, input logic last);
    int e_sum;
    logic [EW-1:0] e;
    m_total += int'(x) * int'(y);
    m_n++;
    if (last) begin
`ifdef SAT_EN
      e_sum = (m_total > 4095) ? 4095 : m_total;
`else
      e_sum = m_total % 4096;
`endif
      e = {(m_total > 4095) ? 1'b1 : 1'b0, CNT_W'(m_n % 32), ACC_W'(e_sum)};
      exp_q.push_back(e);
      m_total = 0;
      m_n     = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("sb_out_sum",   32'(out_sum),   32'(e[ACC_W-1:0]));
        check("sb_out_count", 32'(out_count), 32'(e[ACC_W +: CNT_W]));
        check("sb_out_ovf",   32'(out_ovf),   32'(e[EW-1]));
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_pair(input logic [IN_W-1:0] x, input logic [IN_W-1:0] y,
                           input logic last, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_last  = last;
    while (!in_ready && waited < 64) begin
      if (waited >= 3) out_ready = 1'b1;
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      model_pair(x, y, last);
    end
  endtask

  task automatic wait_out_valid();
    int g = 0;
    while (!out_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("out_valid_timeout", 32'(out_valid), 1);
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_pending", 32'(exp_q.size()), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int len;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    m_total   = 0;
    m_n       = 0;

    // reset state
    #12;
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum",   32'(out_sum),   0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_out_ovf",   32'(out_ovf),   0);
    check("rst_mult_x",    32'(mult_x),    0);
    check("rst_mult_y",    32'(mult_y),    0);
    check("rst_state",     32'(dbg_state), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single pair, latency T+2, in_ready back at T+3
    out_ready = 1'b1;
    send_pair(4'd3, 4'd5, 1'b1, w);
    check("t1_wait", 32'(w), 0);
    @(negedge clk);
    check("t1_valid_T1", 32'(out_valid), 0);
    check("t1_ready_T1", 32'(in_ready),  0);
    check("t1_mult_x",   32'(mult_x),    3);
    check("t1_mult_y",   32'(mult_y),    5);
    @(negedge clk);
    check("t1_valid_T2", 32'(out_valid), 1);
    check("t1_state_T2", 32'(dbg_state), 1);
    check("t1_sum_T2",   32'(out_sum),   15);
    @(negedge clk);
    check("t1_valid_T3", 32'(out_valid), 0);
    check("t1_ready_T3", 32'(in_ready),  1);
    @(posedge clk); #1;

    // 2: four 15x15 back to back
    for (int i = 0; i < 4; i++) begin
      send_pair(4'd15, 4'd15, (i == 3), w);
      check("t2_ready_b2b", 32'(w), 0);
    end
    drain();

    // 3: hold result under backpressure
    out_ready = 1'b0;
    send_pair(4'd1, 4'd2, 1'b0, w);
    send_pair(4'd3, 4'd4, 1'b1, w);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(out_valid), 1);
      check("t3_hold_ready", 32'(in_ready),  0);
      check("t3_hold_sum",   32'(out_sum),   14);
      check("t3_hold_count", 32'(out_count), 2);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_rel_valid", 32'(out_valid), 0);
    check("t3_rel_ready", 32'(in_ready),  1);
    @(posedge clk); #1;

    // 4: nineteen 15x15 pairs overflow the accumulator
    for (int i = 0; i < 19; i++) send_pair(4'd15, 4'd15, (i == 18), w);
    wait_out_valid();
    check("t4_count", 32'(out_count), 19);
    check("t4_ovf",   32'(out_ovf),   1);
    drain();

    // 5: reset mid-vector discards the partial sum
    send_pair(4'd7, 4'd7, 1'b0, w);
    send_pair(4'd2, 4'd3, 1'b0, w);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid",  32'(out_valid), 0);
    check("t5_rst_sum",    32'(out_sum),   0);
    check("t5_rst_count",  32'(out_count), 0);
    check("t5_rst_mult_x", 32'(mult_x),    0);
    check("t5_rst_ready",  32'(in_ready),  1);
    m_total = 0;
    m_n     = 0;
    exp_q.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_pair(4'd1, 4'd1, 1'b1, w);
    drain();

    // 6: back-to-back vectors with in_valid held, bubble on in_ready
    send_pair(4'd2, 4'd2, 1'b1, w);
    in_valid = 1'b1;
    send_pair(4'd3, 4'd3, 1'b0, w);
    check("t6_bubble", 32'(w), 2);
    send_pair(4'd1, 4'd4, 1'b1, w);
    check("t6_in_vec", 32'(w), 0);
    drain();

    // randomized vectors with random backpressure and idle gaps
    for (int v = 0; v < 12; v++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 24) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #1;
        end
        send_pair(IN_W'($urandom_range(0, 15)), IN_W'($urandom_range(0, 15)), (i == len - 1), w);
      end
    end
    drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
